// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the multicycle sequencer (master) and the LEGv8
// datapath, controller and memories (slave).
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  // Run control
  logic             start;
  logic             stop;
  // Memory handshakes
  logic             imemReq;
  logic             imemAck;
  logic             dmemReq;
  logic             dmemAck;
  logic             dmemWe;
  // Controller decode of the current IR and ALU zero flag
  logic             memRead;
  logic             memWrite;
  logic             regWrite;
  logic             branch;
  logic             uncondBranch;
  logic             output0;
  // Datapath strobes
  logic             irWrite;
  logic             aluEn;
  logic             regFileWe;
  logic             pcWrite;
  logic             pcSrc;
  // Status
  logic             busy;
  logic             error;
  logic [2:0]       state;
  logic [CNT_W-1:0] retireCount;

  modport master (
    input  start, stop, imemAck, dmemAck,
    input  memRead, memWrite, regWrite, branch, uncondBranch, output0,
    output imemReq, irWrite, aluEn, dmemReq, dmemWe, regFileWe, pcWrite, pcSrc,
    output busy, error, state, retireCount
  );

  modport slave (
    output start, stop, imemAck, dmemAck,
    output memRead, memWrite, regWrite, branch, uncondBranch, output0,
    input  imemReq, irWrite, aluEn, dmemReq, dmemWe, regFileWe, pcWrite, pcSrc,
    input  busy, error, state, retireCount
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer gating the LEGv8 datapath strobes.
// Optional retired-instruction counter is built only when PERF_CNT_EN is defined.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_sequencer_if.master bus
);

  localparam int               TMO_W    = $clog2(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic branch;
    logic uncond_branch;
  } ctrl_t;

  state_t           r_state;
  state_t           w_next;
  ctrl_t            r_ctrl;
  logic             r_take_br;
  logic [TMO_W-1:0] r_tmo;
  logic             w_waiting;
  logic             w_timeout;

  // A wait cycle is one where a request is up and its ack has not arrived.
  assign w_waiting = ((r_state == S_FETCH) && !bus.imemAck) ||
                     ((r_state == S_MEM)   && !bus.dmemAck);
  assign w_timeout = w_waiting && (r_tmo == TMO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_next        = r_state;
    bus.imemReq   = 1'b0;
    bus.irWrite   = 1'b0;
    bus.aluEn     = 1'b0;
    bus.dmemReq   = 1'b0;
    bus.dmemWe    = 1'b0;
    bus.regFileWe = 1'b0;
    bus.pcWrite   = 1'b0;
    bus.pcSrc     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_FETCH;
      end
      S_FETCH: begin
        bus.imemReq = 1'b1;
        bus.irWrite = bus.imemAck;
        if (bus.imemAck)     w_next = S_DECODE;
        else if (w_timeout)  w_next = S_ERROR;
      end
      S_DECODE: begin
        w_next = (bus.memRead && bus.memWrite) ? S_ERROR : S_EXEC;
      end
      S_EXEC: begin
        bus.aluEn = 1'b1;
        w_next    = (r_ctrl.mem_read || r_ctrl.mem_write) ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.dmemReq = 1'b1;
        bus.dmemWe  = r_ctrl.mem_write;
        if (bus.dmemAck)     w_next = S_WB;
        else if (w_timeout)  w_next = S_ERROR;
      end
      S_WB: begin
        bus.regFileWe = r_ctrl.reg_write;
        bus.pcWrite   = 1'b1;
        bus.pcSrc     = r_take_br;
        w_next        = (bus.stop || !bus.start) ? S_IDLE : S_FETCH;
      end
      S_ERROR: begin
        w_next = S_ERROR;
      end
      default: begin
        w_next = S_ERROR;
      end
    endcase
  end

  assign bus.busy  = (r_state != S_IDLE);
  assign bus.error = (r_state == S_ERROR);
  assign bus.state = r_state;

  // Decode bits are frozen at DECODE so the controller may change under a new IR
  // later; the branch decision is frozen at EXEC while the ALU flag is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_take_br <= 1'b0;
      r_tmo     <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_ctrl <= '{mem_read:      bus.memRead,
                    mem_write:     bus.memWrite,
                    reg_write:     bus.regWrite,
                    branch:        bus.branch,
                    uncond_branch: bus.uncondBranch};
      end
      if (r_state == S_EXEC) begin
        r_take_br <= r_ctrl.uncond_branch | (r_ctrl.branch & bus.output0);
      end
      // Any state change (in particular entry to FETCH or MEM) restarts the timeout.
      if (w_next != r_state) begin
        r_tmo <= '0;
      end else if (w_waiting) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire <= '0;
    end else if (r_state == S_WB) begin
      r_retire <= r_retire + CNT_W'(1);
    end
  end

  assign bus.retireCount = r_retire;
`else
  assign bus.retireCount = {CNT_W{1'b0}};
`endif

endmodule
